// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO and issues them one at a
// time to a registered N-bit signed ALU. Each result is captured and handed to the
// consumer over a valid/ready handshake, tagged with its opcode.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both 1.
// Valid never depends combinationally on ready. Once res_valid is raised, it holds
// res_data, res_opcode and res_illegal stable until the transfer.
module alu_cmd_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_opcode,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic         alu_ena,
  output logic [1:0]   alu_opcode,
  output logic [N-1:0] alu_data1,
  output logic [N-1:0] alu_data2,
  input  logic [N:0]   alu_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N:0]   res_data,
  output logic [1:0]   res_opcode,
  output logic         res_illegal,
  output logic [15:0]  op_count,
  output logic [1:0]   fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 2 + 2 * N;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  logic issue_load;
  logic capture_en;
  logic handoff;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = issue_load;
  assign head      = mem[rd_ptr];
  assign fsm_state = state_q;

  // FIFO storage: write the incoming command at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one op in flight, result must be handed off before the next issue
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (res_ready) state_d = empty ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: strobes that drive the registered datapath below
  always_comb begin
    issue_load = 1'b0;
    capture_en = 1'b0;
    handoff    = 1'b0;
    case (state_q)
      IDLE:    issue_load = !empty;
      CAPTURE: capture_en = 1'b1;
      HOLD: begin
        handoff    = res_ready;
        issue_load = res_ready & !empty;
      end
      default: ;
    endcase
  end

  // ALU drive: load operands on the issue edge; they hold while alu_ena is low
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ena    <= 1'b0;
      alu_opcode <= 2'b00;
      alu_data1  <= '0;
      alu_data2  <= '0;
    end else begin
      alu_ena <= issue_load;
      if (issue_load) begin
        {alu_opcode, alu_data1, alu_data2} <= head;
      end
    end
  end

  // Result capture and consumer handshake; alu_opcode still reflects the issued op here
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_opcode  <= 2'b00;
      res_illegal <= 1'b0;
    end else if (capture_en) begin
      res_valid   <= 1'b1;
      res_data    <= alu_y;
      res_opcode  <= alu_opcode;
      res_illegal <= (alu_opcode == 2'b11);
    end else if (handoff) begin
      res_valid   <= 1'b0;
    end
  end

  // Count of results handed off, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (handoff && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule
